// File: rtl/req_encoder_4to2_pkg.sv
// rtl/req_encoder_4to2_pkg.sv - shared constants, index type and one-hot helper for the request encoder
package enc_pkg;

    localparam int N_DEF     = 4;
    localparam int W_DEF     = 2;
    localparam int CNT_W_DEF = 8;
    localparam int N_MAX     = 16;

    typedef logic [W_DEF-1:0] idx_t;

    // Wide enough for the largest supported N; callers slice to their own width.
    function automatic logic [N_MAX-1:0] onehot_of(input logic [3:0] idx);
        logic [N_MAX-1:0] m;
        m      = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/req_encoder_4to2_if.sv
// rtl/req_encoder_4to2_if.sv - valid/ready index output port of the request encoder
interface req_encoder_4to2_if #(
    parameter int W = 2
);
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_idx;

    modport master (output out_valid, output out_idx, input out_ready);
    modport slave  (input out_valid, input out_idx, output out_ready);
endinterface

// File: rtl/req_encoder_4to2_prio_pick_msb.sv
// rtl/req_encoder_4to2_prio_pick_msb.sv - combinational highest-set-bit finder, inverse of the 2-to-4 decoder
module prio_pick_msb #(
    parameter int N = 4,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] vec,
    output logic         found,
    output logic [W-1:0] idx
);

    // Ascending scan: the last set bit seen is the highest, so it wins.
    always_comb begin
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                found = 1'b1;
                idx   = W'(i);
            end
        end
    end

endmodule

// File: rtl/req_encoder_4to2.sv
// rtl/req_encoder_4to2.sv - latches request lines as pending and streams the highest pending index
module req_encoder_4to2
    import enc_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int W     = $clog2(N),
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic                 flush,
    req_encoder_4to2_if.master   out_if,
    output logic [N-1:0]         pending,
    output logic [CNT_W-1:0]     coalesce_cnt
);

    localparam int PW = $clog2(N + 1);

    logic [N-1:0]     pending_q, pending_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     out_idx_q, out_idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             found;
    logic [W-1:0]     pick_idx;
    logic             load;
    logic [N_MAX-1:0] oh;
    logic [N-1:0]     load_mask;
    logic [PW-1:0]    coal;
    logic [CNT_W:0]   sum;

    prio_pick_msb #(.N(N), .W(W)) u_pick (
        .vec   (pending_q),
        .found (found),
        .idx   (pick_idx)
    );

    always_comb begin
        load      = found && (!out_valid_q || out_if.out_ready);
        oh        = onehot_of(4'(pick_idx));
        load_mask = load ? oh[N-1:0] : '0;
    end

    // A request on a bit that is already pending and not leaving this edge is coalesced.
    always_comb begin
        coal = '0;
        for (int i = 0; i < N; i++) begin
            coal = coal + PW'(req[i] & pending_q[i] & ~load_mask[i]);
        end
        sum = {1'b0, cnt_q} + (CNT_W + 1)'(coal);
    end

    always_comb begin
        pending_d   = (pending_q & ~load_mask) | req;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        cnt_d       = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
        if (load) begin
            out_valid_d = 1'b1;
            out_idx_d   = pick_idx;
        end else if (out_valid_q && out_if.out_ready) begin
            out_valid_d = 1'b0;
        end
        // Flush drops everything queued, including this cycle's requests, but keeps the count.
        if (flush) begin
            pending_d   = '0;
            out_valid_d = 1'b0;
            out_idx_d   = out_idx_q;
            cnt_d       = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            cnt_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_if.out_valid = out_valid_q;
    assign out_if.out_idx   = out_idx_q;
    assign pending          = pending_q;
    assign coalesce_cnt     = cnt_q;

endmodule
